// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared state encoding, default MAC latency and MAC mode codes
package dsp_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_HOLD} state_t;
  localparam int DSP_LAT_DEFAULT = 2;
  localparam logic [1:0] MODE_MACC_U = 2'd0;
  localparam logic [1:0] MODE_MACC_S = 2'd1;
  localparam logic [1:0] MODE_MSUB_U = 2'd2;
  localparam logic [1:0] MODE_MSUB_S = 2'd3;
endpackage

// File: rtl/dsp_seq_addr_gen.sv
// dsp_seq_addr_gen: wrapping RAM read address plus issued/consumed term counters
module dsp_seq_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_issue,
  input  logic              i_consume,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_issued_done,
  output logic              o_consumed_done
);
  logic [ADDR_W-1:0] r_addr, r_len, r_issued, r_consumed;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_consumed <= '0;
    end else if (i_load) begin
      r_addr     <= i_base;
      r_len      <= i_len;
      r_issued   <= '0;
      r_consumed <= '0;
    end else begin
      if (i_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_issued <= r_issued + ADDR_W'(1);
      end
      if (i_consume) r_consumed <= r_consumed + ADDR_W'(1);
    end
  assign o_rd_addr       = r_addr;
  assign o_issued_done   = r_issued == r_len;
  // high while the final term is being consumed
  assign o_consumed_done = r_consumed == r_len - ADDR_W'(1);
endmodule

// File: rtl/dsp_dot_seq.sv
// dsp_dot_seq: sequences a DSP MAC block through one dot-product job from sync RAM
// and returns the accumulated 64-bit result on a valid/ready port.
module dsp_dot_seq
  import dsp_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LAT    = DSP_LAT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [1:0]        i_mode_cfg,
  input  logic              i_rnd_cfg,
  input  logic              i_sat_cfg,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_oper,
  input  logic [31:0]       i_rd_coef,
  output logic [31:0]       o_dsp_oper,
  output logic [31:0]       o_dsp_coef,
  output logic              o_dsp_enable,
  output logic              o_dsp_clr,
  output logic [1:0]        o_dsp_mode,
  output logic              o_dsp_rnd,
  output logic              o_dsp_sat,
  input  logic [63:0]       i_dsp_mac_out,
  output logic [63:0]       o_res,
  output logic              o_res_valid,
  input  logic              i_res_ready
);
  localparam int CW = $clog2(LAT + 1);
  state_t            r_state, w_next;
  logic [CW-1:0]     r_drain;
  logic [1:0]        r_mode;
  logic              r_rnd, r_sat;
  logic [63:0]       r_res;
  logic              w_start, w_drain_last, w_issued_done, w_consumed_done;
  assign w_start      = r_state == S_IDLE && i_start;
  assign w_drain_last = r_drain == CW'(LAT - 1);
  dsp_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_load         (w_start),
    .i_base         (i_base),
    .i_len          (i_len),
    .i_issue        (o_rd_en),
    .i_consume      (o_dsp_enable),
    .o_rd_addr      (o_rd_addr),
    .o_issued_done  (w_issued_done),
    .o_consumed_done(w_consumed_done)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = i_len == '0 ? S_HOLD : S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (w_consumed_done) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_HOLD;
      S_HOLD:  if (i_res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_drain <= '0;
      r_mode  <= '0;
      r_rnd   <= 1'b0;
      r_sat   <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= r_state == S_DRAIN ? r_drain + CW'(1) : '0;
      if (w_start) begin
        r_mode <= i_mode_cfg;
        r_rnd  <= i_rnd_cfg;
        r_sat  <= i_sat_cfg;
      end
      if (w_start && i_len == '0) r_res <= '0;
      else if (r_state == S_DRAIN && w_drain_last) r_res <= i_dsp_mac_out;
    end
  // the read issued in CLEAR feeds the first FEED cycle, so the last FEED cycle issues nothing
  assign o_busy       = r_state != S_IDLE;
  assign o_dsp_clr    = r_state == S_CLEAR;
  assign o_dsp_enable = r_state == S_FEED;
  assign o_rd_en      = o_dsp_clr || (o_dsp_enable && !w_issued_done);
  assign o_res_valid  = r_state == S_HOLD;
  assign o_dsp_oper   = i_rd_oper;
  assign o_dsp_coef   = i_rd_coef;
  assign o_dsp_mode   = r_mode;
  assign o_dsp_rnd    = r_rnd;
  assign o_dsp_sat    = r_sat;
  assign o_res        = r_res;
endmodule

// File: tb/tb_dsp_dot_seq.sv
// tb_dsp_dot_seq: random dot-product jobs against a RAM + MAC environment and a
// plain-arithmetic result/latency model.
module tb_dsp_dot_seq;
  localparam int LAT = 2;
  logic        clk = 1'b0;
  logic        i_rst_n, i_start, i_rnd_cfg, i_sat_cfg, i_res_ready;
  logic [7:0]  i_len, i_base;
  logic [1:0]  i_mode_cfg;
  logic        o_busy, o_rd_en, o_dsp_enable, o_dsp_clr, o_dsp_rnd, o_dsp_sat, o_res_valid;
  logic [7:0]  o_rd_addr;
  logic [31:0] rd_oper, rd_coef, o_dsp_oper, o_dsp_coef;
  logic [1:0]  o_dsp_mode;
  logic [63:0] mac_acc = '0, mac_pipe = '0, o_res;
  logic [31:0] oper_mem [256];
  logic [31:0] coef_mem [256];
  int          errors = 0, checks = 0;
  int          clr_cnt, en_cnt, rd_cnt, addr_bad, both_cnt = 0;
  logic [7:0]  exp_addr;

  always #5 clk = ~clk;

  dsp_dot_seq #(.ADDR_W(8), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len), .i_base(i_base),
    .i_mode_cfg(i_mode_cfg), .i_rnd_cfg(i_rnd_cfg), .i_sat_cfg(i_sat_cfg),
    .o_busy(o_busy), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_oper(rd_oper), .i_rd_coef(rd_coef), .o_dsp_oper(o_dsp_oper), .o_dsp_coef(o_dsp_coef),
    .o_dsp_enable(o_dsp_enable), .o_dsp_clr(o_dsp_clr), .o_dsp_mode(o_dsp_mode),
    .o_dsp_rnd(o_dsp_rnd), .o_dsp_sat(o_dsp_sat), .i_dsp_mac_out(mac_pipe),
    .o_res(o_res), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready)
  );

  // 1-cycle sync RAM and a MAC whose output is final LAT cycles after the last enable
  always @(posedge clk) begin
    if (o_rd_en) begin
      rd_oper <= oper_mem[o_rd_addr];
      rd_coef <= coef_mem[o_rd_addr];
    end
    if (o_dsp_clr) mac_acc <= '0;
    else if (o_dsp_enable) mac_acc <= mac_acc + 64'(o_dsp_oper) * 64'(o_dsp_coef);
    mac_pipe <= mac_acc;
  end

  always @(negedge clk) begin
    if (o_rd_en) begin
      if (o_rd_addr !== exp_addr) addr_bad++;
      exp_addr <= exp_addr + 8'd1;
      rd_cnt++;
    end
    if (o_dsp_clr) clr_cnt++;
    if (o_dsp_enable) en_cnt++;
    if (o_dsp_clr && o_dsp_enable) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ctl();
    return {47'b0, o_busy, o_rd_en, o_rd_addr, o_dsp_enable, o_dsp_clr,
            o_dsp_mode, o_dsp_rnd, o_dsp_sat, o_res_valid};
  endfunction

  // called #1 after a rising edge with the DUT idle
  task automatic run_job(input logic [7:0] len, input logic [7:0] base, input logic [1:0] mode,
                         input logic rnd, input logic sat, input int hold, input logic poke);
    logic [63:0] exp = '0;
    int n = 1;
    for (int i = 0; i < int'(len); i++)
      exp += 64'(oper_mem[8'(int'(base) + i)]) * 64'(coef_mem[8'(int'(base) + i)]);
    clr_cnt = 0; en_cnt = 0; rd_cnt = 0; addr_bad = 0; exp_addr = base;
    i_len = len; i_base = base; i_mode_cfg = mode; i_rnd_cfg = rnd; i_sat_cfg = sat; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = poke; i_mode_cfg = ~mode; i_rnd_cfg = ~rnd; i_sat_cfg = ~sat;
    i_len = 8'($urandom); i_base = 8'($urandom);
    while (!o_res_valid && n < 600) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), len == 0 ? 64'd1 : 64'(int'(len) + LAT + 2));
    chk("res", o_res, exp);
    chk("clr_pulses", 64'(clr_cnt), len == 0 ? 64'd0 : 64'd1);
    chk("en_cycles", 64'(en_cnt), 64'(len));
    chk("rd_count", 64'(rd_cnt), 64'(len));
    chk("rd_addr_seq", 64'(addr_bad), 64'd0);
    chk("cfg_latched", 64'({o_dsp_mode, o_dsp_rnd, o_dsp_sat}), 64'({mode, rnd, sat}));
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    if (hold > 0) chk("hold_stable", {o_res[62:0], o_res_valid}, {exp[62:0], 1'b1});
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0; i_start = 1'b0;
    chk("after_ready", 64'({o_busy, o_res_valid}), 64'd0);
    chk("res_kept", o_res, exp);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_res_ready = 1'b0; i_len = '0; i_base = '0;
    i_mode_cfg = '0; i_rnd_cfg = 1'b0; i_sat_cfg = 1'b0;
    for (int i = 0; i < 256; i++) begin
      oper_mem[i] = $urandom;
      coef_mem[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      oper_mem[i] = 32'(i + 1);
      coef_mem[i] = 32'(i + 5);
    end
    #7;
    chk("reset_ctl", ctl(), 64'd0);
    chk("reset_res", o_res, 64'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    run_job(8'd4, 8'h00, 2'd2, 1'b1, 1'b0, 2, 1'b0);
    chk("t1_res70", o_res, 64'd70);
    run_job(8'd0, 8'h33, 2'd1, 1'b0, 1'b1, 0, 1'b0);
    chk("t2_res0", o_res, 64'd0);
    run_job(8'd3, 8'hFE, 2'd3, 1'b1, 1'b1, 1, 1'b0);
    run_job(8'd4, 8'h10, 2'd1, 1'b0, 1'b1, 10, 1'b1);
    run_job(8'd2, 8'h20, 2'd0, 1'b0, 1'b0, 0, 1'b0);
    // reset asserted in the second FEED cycle of a LEN=4 job
    i_len = 8'd4; i_base = 8'h00; i_mode_cfg = 2'd3; i_rnd_cfg = 1'b1; i_sat_cfg = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_feed", 64'({o_busy, o_dsp_enable}), 64'd3);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 64'd0);
    chk("async_rst_res", o_res, 64'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    oper_mem[8'h40] = 32'd3;
    coef_mem[8'h40] = 32'd4;
    run_job(8'd1, 8'h40, 2'd2, 1'b0, 1'b1, 0, 1'b0);
    chk("post_rst_res12", o_res, 64'd12);
    for (int j = 0; j < 8; j++)
      run_job(8'($urandom_range(0, 20)), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    run_job(8'd255, 8'($urandom), 2'd1, 1'b1, 1'b0, 1, 1'b1);
    chk("clr_en_exclusive", 64'(both_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
